// File: rtl/para_tx_pkg.sv
// rtl/para_tx_pkg.sv - shared types and helpers for the parameter stream transmitter
//
// Purpose: state encoding, section index constants and the stream-length helper
//          used by para_stream_tx and para_sec_cnt.
// Ports:   none (package).

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

package para_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [2:0] SEC_RSIGN = 3'd0;
  localparam logic [2:0] SEC_BN_A  = 3'd1;
  localparam logic [2:0] SEC_BN_B  = 3'd2;
  localparam logic [2:0] SEC_BETA  = 3'd3;
  localparam logic [2:0] SEC_GAMMA = 3'd4;
  localparam logic [2:0] SEC_ZETA  = 3'd5;

  // rsign section plus five per-channel sections (bn_a, bn_b, beta, gamma, zeta)
  function automatic int para_total(input int fm_depth, input int ch_num);
    return fm_depth + 5 * ch_num;
  endfunction

endpackage

// File: rtl/para_sec_cnt.sv
// rtl/para_sec_cnt.sv - word index to section index and last-word flag
//
// Purpose: maps a stream word index onto its section (0 = rsign, 1..5 = bn_a ..
//          zeta) and flags the final word of the stream.
// Ports:
//   cnt      in   CNT_W  word index within the stream
//   section  out  3      section of word cnt (indices past the end stay at zeta)
//   last     out  1      cnt is the final word index (TOTAL-1)

module para_sec_cnt
  import para_tx_pkg::*;
#(
  parameter int FM_DEPTH    = 128,
  parameter int CHANNEL_NUM = 256,
  parameter int CNT_W       = 11
) (
  input  logic [CNT_W-1:0] cnt,
  output logic [2:0]       section,
  output logic             last
);

  localparam int TOTAL = para_total(FM_DEPTH, CHANNEL_NUM);

  // Threshold compares instead of a divide: section k starts at
  // FM_DEPTH + (k-1)*CHANNEL_NUM, all of which are elaboration constants.
  always_comb begin
    section = SEC_RSIGN;
    for (int k = 1; k <= 5; k++) begin
      if (int'(cnt) >= FM_DEPTH + (k - 1) * CHANNEL_NUM) begin
        section = 3'(k);
      end
    end
  end

  assign last = (cnt == CNT_W'(TOTAL - 1));

endmodule

// File: rtl/para_stream_tx.sv
// rtl/para_stream_tx.sv - streams a layer's parameter words from memory to its para_loader
//
// Purpose: on start, reads TOTAL words from a 1-cycle-latency memory and streams
//          them on para_out/data_e_para with mode low; after the last word and
//          SETTLE idle cycles, raises mode (calculate) and pulses done.
// Ports:
//   clk          in   1       system clock
//   rst          in   1       synchronous reset, active-high
//   start        in   1       pulse: begin (re)load; honoured only in IDLE/RUN
//   mem_rd       out  1       memory read strobe
//   mem_addr     out  ADDR_W  memory read address
//   mem_rdata    in   PARA_W  read data, valid one cycle after mem_rd
//   para_out     out  PARA_W  parameter word to para_loader
//   data_e_para  out  1       para_out valid
//   mode         out  1       0 = reload, 1 = calculate
//   section      out  3       section index of the current para_out word
//   busy         out  1       load or flush in progress
//   done         out  1       one-cycle pulse as mode rises

module para_stream_tx
  import para_tx_pkg::*;
#(
  parameter int FM_DEPTH    = 128,
  parameter int CHANNEL_NUM = 256,
  parameter int PARA_W      = `PARA_WIDTH,
  parameter int ADDR_W      = 11,
  parameter int BASE_ADDR   = 0,
  parameter int SETTLE      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [PARA_W-1:0]        mem_rdata,
  output logic signed [PARA_W-1:0] para_out,
  output logic                     data_e_para,
  output logic                     mode,
  output logic [2:0]               section,
  output logic                     busy,
  output logic                     done
);

  localparam int TOTAL = para_total(FM_DEPTH, CHANNEL_NUM);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SET_W = $clog2(SETTLE + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_done;
  logic             rd_last;
  logic             wr_last;
  logic [2:0]       rd_sec;
  logic             mem_rd_q;
  logic             done_q;
  logic             start_ok;
  logic             unused_sec_cnt;

  // Read side only needs the last-word flag, write side only the section.
  para_sec_cnt #(
    .FM_DEPTH    (FM_DEPTH),
    .CHANNEL_NUM (CHANNEL_NUM),
    .CNT_W       (CNT_W)
  ) u_rd_sec (
    .cnt     (rd_cnt),
    .section (rd_sec),
    .last    (rd_last)
  );

  para_sec_cnt #(
    .FM_DEPTH    (FM_DEPTH),
    .CHANNEL_NUM (CHANNEL_NUM),
    .CNT_W       (CNT_W)
  ) u_wr_sec (
    .cnt     (wr_cnt),
    .section (section),
    .last    (wr_last)
  );

  assign unused_sec_cnt = ^{rd_sec, wr_last};

  // FLUSH lasts SETTLE+1 cycles: one for the last read's data to land, then SETTLE idle.
  assign settle_done = (settle_cnt == SET_W'(SETTLE));
  assign start_ok    = start && ((state == IDLE) || (state == RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = LOAD;
      LOAD:    if (rd_last)     state_nxt = FLUSH;
      FLUSH:   if (settle_done) state_nxt = RUN;
      RUN:     if (start)       state_nxt = LOAD;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = (state == LOAD);
    mem_addr = mem_rd ? (ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt)) : '0;
    mode     = (state == RUN);
    busy     = (state == LOAD) || (state == FLUSH);
    done     = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      settle_cnt  <= '0;
      mem_rd_q    <= 1'b0;
      data_e_para <= 1'b0;
      para_out    <= '0;
      done_q      <= 1'b0;
    end else begin
      mem_rd_q    <= mem_rd;
      data_e_para <= mem_rd_q;
      if (mem_rd_q) begin
        para_out <= mem_rdata;
      end

      done_q <= (state == FLUSH) && settle_done;

      if ((state == FLUSH) && !settle_done) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      // Counters saturate at TOTAL; a restart only happens once the previous
      // stream has fully drained, so clearing both here is safe.
      if (start_ok) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (mem_rd && (rd_cnt != CNT_W'(TOTAL))) begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
        if (data_e_para && (wr_cnt != CNT_W'(TOTAL))) begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_para_stream_tx.sv
// tb/tb_para_stream_tx.sv - self-checking bench for para_stream_tx

module tb_para_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     = 1'b1;
  logic d_start = 1'b0;
  logic s_start = 1'b0;

  logic        d_mem_rd, d_de, d_mode, d_busy, d_done;
  logic [10:0] d_mem_addr;
  logic [15:0] d_mem_rdata, d_para_out;
  logic [2:0]  d_section;

  logic        s_mem_rd, s_de, s_mode, s_busy, s_done;
  logic [10:0] s_mem_addr;
  logic [15:0] s_mem_rdata, s_para_out;
  logic [2:0]  s_section;

  para_stream_tx #(
    .FM_DEPTH(128), .CHANNEL_NUM(256), .PARA_W(16), .ADDR_W(11), .BASE_ADDR(0), .SETTLE(2)
  ) u_dut (
    .clk(clk), .rst(rst), .start(d_start),
    .mem_rd(d_mem_rd), .mem_addr(d_mem_addr), .mem_rdata(d_mem_rdata),
    .para_out(d_para_out), .data_e_para(d_de), .mode(d_mode),
    .section(d_section), .busy(d_busy), .done(d_done)
  );

  para_stream_tx #(
    .FM_DEPTH(4), .CHANNEL_NUM(8), .PARA_W(16), .ADDR_W(11), .BASE_ADDR(0), .SETTLE(1)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
    .para_out(s_para_out), .data_e_para(s_de), .mode(s_mode),
    .section(s_section), .busy(s_busy), .done(s_done)
  );

  // Memories hold word == address; junk when not read so stale data shows up.
  always @(posedge clk) d_mem_rdata <= d_mem_rd ? {5'd0, d_mem_addr} : 16'hDEAD;
  always @(posedge clk) s_mem_rdata <= s_mem_rd ? {5'd0, s_mem_addr} : 16'hBEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fm_p  [2] = '{128, 4};
  int ch_p  [2] = '{256, 8};
  int set_p [2] = '{2, 1};

  int n_cmp = 0;
  int n_bad = 0;

  bit          active    [2];
  int          t_start   [2];
  logic [15:0] last_word [2];

  int de_cnt [2], done_cnt [2], first_rd [2], first_addr [2];
  int first_de [2], done_cyc [2], start_cyc [2];
  logic [2:0]  sec_log [2][1408];
  logic [15:0] po_log  [2][1408];

  function automatic int tot_of(input int i);
    return fm_p[i] + 5 * ch_p[i];
  endfunction

  function automatic int exp_section(input int i, input int word);
    if (word < fm_p[i]) return 0;
    return 1 + (word - fm_p[i]) / ch_p[i];
  endfunction

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @cycle %0d: actual=%0d required=%0d", name, i, cyc, act, exp);
    end
  endtask

  task automatic reset_trackers(input int i);
    de_cnt[i]     = 0;
    done_cnt[i]   = 0;
    first_rd[i]   = -1;
    first_addr[i] = -1;
    first_de[i]   = -1;
    done_cyc[i]   = -1;
    start_cyc[i]  = cyc;
  endtask

  // Effect of the inputs that the coming rising edge will sample.
  task automatic model_edge(input int i, input logic st);
    if (rst) begin
      active[i]    = 1'b0;
      last_word[i] = '0;
    end else if (st && (!active[i] || (cyc - t_start[i]) >= tot_of(i) + 2 + set_p[i])) begin
      active[i]  = 1'b1;
      t_start[i] = cyc;
      reset_trackers(i);
    end
  endtask

  // Expected outputs as a timeline relative to the accepted start cycle.
  task automatic observe(input int i, input logic rd, input logic [10:0] addr,
                         input logic [15:0] po, input logic de, input logic md,
                         input logic [2:0] sec, input logic bz, input logic dn);
    int tot, st, rel, word, e_addr;
    logic e_rd, e_de, e_busy, e_mode, e_done;
    logic [15:0] e_po;
    tot    = tot_of(i);
    st     = set_p[i];
    rel    = cyc - t_start[i];
    word   = rel - 3;
    e_rd   = active[i] && rel >= 1 && rel <= tot;
    e_addr = e_rd ? rel - 1 : 0;
    e_de   = active[i] && rel >= 3 && rel <= tot + 2;
    e_busy = active[i] && rel >= 1 && rel <= tot + 1 + st;
    e_mode = active[i] && rel >= tot + 2 + st;
    e_done = active[i] && rel == tot + 2 + st;
    e_po   = e_de ? 16'(word) : last_word[i];
    last_word[i] = e_po;

    chk(i, "mem_rd", rd, e_rd);
    chk(i, "mem_addr", addr, e_addr);
    chk(i, "data_e_para", de, e_de);
    chk(i, "para_out", po, e_po);
    chk(i, "mode", md, e_mode);
    chk(i, "busy", bz, e_busy);
    chk(i, "done", dn, e_done);
    chk(i, "mode_with_data", md & de, 0);
    if (e_de) chk(i, "section", sec, exp_section(i, word));

    if (rd && first_rd[i] < 0) begin
      first_rd[i]   = cyc;
      first_addr[i] = int'(addr);
    end
    if (de) begin
      if (first_de[i] < 0) first_de[i] = cyc;
      if (de_cnt[i] < 1408) begin
        sec_log[i][de_cnt[i]] = sec;
        po_log[i][de_cnt[i]]  = po;
      end
      de_cnt[i]++;
    end
    if (dn) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
    end
  endtask

  task automatic cycle();
    model_edge(0, d_start);
    model_edge(1, s_start);
    @(negedge clk);
    observe(0, d_mem_rd, d_mem_addr, d_para_out, d_de, d_mode, d_section, d_busy, d_done);
    observe(1, s_mem_rd, s_mem_addr, s_para_out, s_de, s_mode, s_section, s_busy, s_done);
  endtask

  task automatic wait_done(input int i, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      cycle();
      seen = (i == 0) ? d_done : s_done;
    end
    chk(i, "done_within_budget", seen, 1);
  endtask

  task automatic wait_words(input int i, input int words, input int budget);
    for (int n = 0; n < budget && de_cnt[i] < words; n++) cycle();
    chk(i, "words_reached", de_cnt[i], words);
  endtask

  task automatic pulse_start(input int i);
    if (i == 0) d_start = 1'b1; else s_start = 1'b1;
    cycle();
    d_start = 1'b0;
    s_start = 1'b0;
  endtask

  int hist [6];
  int exp_hist [6] = '{4, 8, 8, 8, 8, 8};
  int word_pick [6] = '{0, 1, 127, 128, 700, 1407};

  initial begin
    for (int i = 0; i < 2; i++) begin
      active[i]    = 1'b0;
      t_start[i]   = 0;
      last_word[i] = '0;
      reset_trackers(i);
    end

    // Test 1: reset for three cycles, start in cycle 10
    repeat (3) cycle();
    rst = 1'b0;
    chk(0, "reset_mode", d_mode, 0);
    chk(0, "reset_para_out", d_para_out, 0);
    chk(0, "reset_busy", d_busy, 0);
    while (cyc < 10) cycle();
    pulse_start(0);
    wait_done(0, 2000);
    chk(0, "first_rd_cycle", first_rd[0], 11);
    chk(0, "first_addr", first_addr[0], 0);
    chk(0, "first_de_cycle", first_de[0], 13);
    chk(0, "done_cycle", done_cyc[0], 1422);
    chk(0, "word_count", de_cnt[0], 1408);
    chk(0, "done_count", done_cnt[0], 1);

    // Test 2: word order and section boundaries
    for (int k = 0; k < 6; k++) chk(0, "word_value", po_log[0][word_pick[k]], word_pick[k]);
    chk(0, "sec_w0", sec_log[0][0], 0);
    chk(0, "sec_w127", sec_log[0][127], 0);
    chk(0, "sec_w128", sec_log[0][128], 1);
    chk(0, "sec_w1151", sec_log[0][1151], 4);
    chk(0, "sec_w1152", sec_log[0][1152], 5);
    chk(0, "sec_w1407", sec_log[0][1407], 5);

    // Test 3/5: restart from RUN, extra start at word 500 is ignored
    cycle();
    chk(0, "mode_in_run", d_mode, 1);
    pulse_start(0);
    chk(0, "mode_after_restart", d_mode, 0);
    chk(0, "busy_after_restart", d_busy, 1);
    wait_words(0, 500, 2000);
    pulse_start(0);
    wait_done(0, 2000);
    chk(0, "word_count_ignored_start", de_cnt[0], 1408);
    chk(0, "done_latency", done_cyc[0] - start_cyc[0], 1412);
    chk(0, "done_count_ignored_start", done_cnt[0], 1);
    chk(0, "first_rd_latency", first_rd[0] - start_cyc[0], 1);

    // Test 4: reset at word 700, then a full reload
    cycle();
    pulse_start(0);
    wait_words(0, 700, 2000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk(0, "rst_mid_de", d_de, 0);
    chk(0, "rst_mid_mode", d_mode, 0);
    chk(0, "rst_mid_busy", d_busy, 0);
    repeat (20) cycle();
    chk(0, "partial_no_done", done_cnt[0], 0);
    chk(0, "partial_no_mode", d_mode, 0);
    pulse_start(0);
    wait_done(0, 2000);
    chk(0, "reload_word_count", de_cnt[0], 1408);
    chk(0, "reload_first_addr", first_addr[0], 0);
    chk(0, "reload_word0", po_log[0][0], 0);
    chk(0, "reload_word1407", po_log[0][1407], 1407);

    // Test 5: small configuration, 44 words, sections 4/8/8/8/8/8
    pulse_start(1);
    wait_done(1, 200);
    chk(1, "small_word_count", de_cnt[1], 44);
    chk(1, "small_done_latency", done_cyc[1] - start_cyc[1], 47);
    chk(1, "small_last_word", po_log[1][43], 43);
    for (int k = 0; k < 6; k++) hist[k] = 0;
    for (int k = 0; k < 44; k++) if (sec_log[1][k] < 3'd6) hist[sec_log[1][k]]++;
    for (int k = 0; k < 6; k++) chk(1, "small_section_len", hist[k], exp_hist[k]);
    cycle();
    pulse_start(1);
    chk(1, "small_mode_after_restart", s_mode, 0);
    wait_done(1, 200);
    chk(1, "small_reload_count", de_cnt[1], 44);
    chk(1, "small_mode_back", s_mode, 1);

    repeat (5) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
